// File: rtl/restoring_divider.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, fixed latency.
// Define DIV_SIGNED_EN for signed two's-complement division; unsigned otherwise.
module restoring_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ready,
  output logic        div_zero,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, RUN, FIX, DONE, ZERO} state_t;

  state_t      state;
  logic [31:0] dvd;    // dividend magnitude, quotient bits shift in at the LSB
  logic [31:0] dvs;
  logic [32:0] rem;
  logic [4:0]  count;
`ifdef DIV_SIGNED_EN
  logic        sign_a;
  logic        sign_b;
`endif

  logic [33:0] shifted;
  logic [33:0] trial;
  logic        trial_ok;

  always_comb begin
    shifted  = {rem, dvd[31]};
    trial    = shifted - {2'b00, dvs};
    trial_ok = ~trial[33];
  end

`ifdef DIV_SIGNED_EN
  function automatic logic [31:0] magnitude(input logic [31:0] x);
    // 0x80000000 maps to unsigned 2^31, which still fits in 32 bits
    return x[31] ? (~x + 32'd1) : x;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      count    <= '0;
`ifdef DIV_SIGNED_EN
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`endif
    end else begin
      ready    <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (b != '0) begin
`ifdef DIV_SIGNED_EN
              dvd    <= magnitude(a);
              dvs    <= magnitude(b);
              sign_a <= a[31];
              sign_b <= b[31];
`else
              dvd    <= a;
              dvs    <= b;
`endif
              rem    <= '0;
              count  <= 5'd31;
              state  <= RUN;
            end else begin
              div_zero <= 1'b1;
              state    <= ZERO;
            end
          end
        end
        RUN: begin
          rem <= trial_ok ? trial[32:0] : shifted[32:0];
          dvd <= {dvd[30:0], trial_ok};
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 5'd1;
          end
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          lo <= (sign_a ^ sign_b) ? (~dvd + 32'd1) : dvd;
          hi <= sign_a ? (~rem[31:0] + 32'd1) : rem[31:0];
`else
          lo <= dvd;
          hi <= rem[31:0];
`endif
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ZERO: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider; signed vectors run when DIV_SIGNED_EN is defined.
module tb_restoring_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        div_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  restoring_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .ready    (ready),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns 1 time unit after the accepting edge E0
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(output int cyc, output int flag_seen);
    cyc = 0;
    flag_seen = 0;
    while (ready !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
      if (div_zero !== 1'b0) flag_seen = 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'd0); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'd0); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_normal();
    int busy_bad = 0;
    int ready_bad = 0;
    int lo_early = 0;
    issue(32'd100, 32'd7);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy_e0 got %b want 1", busy); end
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (busy !== (k <= 33)) busy_bad++;
      if (ready !== (k == 34)) ready_bad++;
      if (k <= 32 && lo !== 32'd0) lo_early++;
    end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL normal_busy_window got %0d bad cycles want 0", busy_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL normal_ready_timing got %0d bad cycles want 0", ready_bad); end
    checks++; if (lo_early != 0) begin errors++; $display("FAIL normal_lo_held got %0d early writes want 0", lo_early); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL normal_lo got %h want %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL normal_hi got %h want %h", hi, 32'd2); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL normal_ready_one_cycle got %b want 0", ready); end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    int cyc;
    int flag;
    issue(32'hFFFF_FFF9, 32'd2);
    wait_ready(cyc, flag);
    checks++; if (cyc != 34) begin errors++; $display("FAIL signed_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(cyc, flag);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL overflow_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL overflow_hi got %h want %h", hi, 32'h0); end
    checks++; if (flag != 0) begin errors++; $display("FAIL overflow_flag got %0d want 0", flag); end
  endtask
`else
  task automatic test_unsigned();
    int cyc;
    int flag;
    issue(32'hFFFF_FFFF, 32'd2);
    wait_ready(cyc, flag);
    checks++; if (cyc != 34) begin errors++; $display("FAIL unsigned_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'h7FFF_FFFF) begin errors++; $display("FAIL unsigned_lo got %h want %h", lo, 32'h7FFF_FFFF); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL unsigned_hi got %h want %h", hi, 32'd1); end
    checks++; if (flag != 0) begin errors++; $display("FAIL unsigned_flag got %0d want 0", flag); end
  endtask
`endif

  task automatic test_div_zero();
    int cyc;
    int flag;
    int ready_seen = 0;
    issue(32'd95, 32'd10);
    wait_ready(cyc, flag);
    checks++; if (lo !== 32'd9 || hi !== 32'd5) begin errors++; $display("FAIL dz_preload got %h/%h want %h/%h", lo, hi, 32'd9, 32'd5); end
    issue(32'd123, 32'd0);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse got %b want 1", div_zero); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL dz_ready got %b want 0", ready); end
    tick();
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_one_cycle got %b want 0", div_zero); end
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready !== 1'b0) ready_seen++;
    end
    checks++; if (ready_seen != 0) begin errors++; $display("FAIL dz_no_ready got %0d want 0", ready_seen); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi_held got %h want %h", hi, 32'd5); end
    checks++; if (lo !== 32'd9) begin errors++; $display("FAIL dz_lo_held got %h want %h", lo, 32'd9); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int flag;
    int ready_seen = 0;
    issue(32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready !== 1'b0) ready_seen++;
    end
    checks++; if (ready_seen != 0) begin errors++; $display("FAIL rst_mid_no_ready got %0d want 0", ready_seen); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_mid_no_write got %h want %h", lo, 32'd0); end
    issue(32'd50, 32'd5);
    wait_ready(cyc, flag);
    checks++; if (cyc != 34) begin errors++; $display("FAIL rst_after_latency got %0d want 34", cyc); end
    checks++; if (lo !== 32'd10) begin errors++; $display("FAIL rst_after_lo got %h want %h", lo, 32'd10); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_after_hi got %h want %h", hi, 32'd0); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first_at = -1;
    issue(32'd100, 32'd7);
    for (int k = 1; k <= 4; k++) tick();
    @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    tick();
    start = 1'b0;
    for (int k = 6; k <= 50; k++) begin
      tick();
      if (ready === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL busy_start_pulses got %0d want 1", pulses); end
    checks++; if (first_at != 34) begin errors++; $display("FAIL busy_start_latency got %0d want 34", first_at); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo got %h want %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi got %h want %h", hi, 32'd2); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_normal();
`ifdef DIV_SIGNED_EN
    test_signed();
`else
    test_unsigned();
`endif
    test_div_zero();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 a  input  32  dividend, captured on the accepting edge.
REQ-006 b  input  32  divisor, captured on the accepting edge.
REQ-007 hi  output  32  remainder register.
REQ-008 lo  output  32  quotient register.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  one-cycle divide-by-zero pulse.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RUN, FIX, DONE, ZERO.
REQ-013 IDLE with start=1 and b!=0: the block SHALL capture |a| and |b| plus the sign bits, clear the partial remainder, load iteration counter=31, and go to RUN.
REQ-014 IDLE with start=1 and b==0: the block SHALL go to ZERO, and hi/lo SHALL be left unchanged.
REQ-015 RUN SHALL perform one restoring step per cycle on a 33-bit partial remainder.
- Shift in the next dividend MSB.
- Trial-subtract the divisor.
- If the result is non-negative, keep it and set the quotient bit to 1.
- Otherwise, restore and set the quotient bit to 0.
REQ-016 RUN SHALL decrement the counter each cycle and go to FIX after the step taken with counter=0 (32 steps total).
REQ-017 FIX SHALL apply signs: quotient negated if sign_a^sign_b; remainder negated if sign_a; results written to lo/hi on the FIX->DONE edge.
REQ-018 DONE SHALL assert ready=1 for exactly one cycle, then return to IDLE.
REQ-019 ZERO SHALL assert div_zero=1 for exactly one cycle with ready=0, then return to IDLE.
REQ-020 Latency SHALL be fixed.
- Accepting edge = E0.
- ready is high in the cycle following E34.
- div_zero is high in the cycle following E0.
REQ-021 start SHALL be ignored while busy=1; no queuing and no restart.
REQ-022 The case a=0x80000000, b=0xFFFFFFFF SHALL wrap: lo=0x80000000, hi=0x00000000; no flag is raised.
REQ-023 hi/lo SHALL hold their last values in IDLE, ZERO and all states preceding the FIX->DONE write.
REQ-024 Magnitude of 0x80000000 SHALL be treated as unsigned 2^31; all internal arithmetic is 33-bit with no truncation before FIX.
REQ-025 ready and div_zero SHALL never be high in the same cycle.

Reset
REQ-026 With reset=1 at a clock edge, the block SHALL force state=IDLE, hi=0, lo=0, ready=0, div_zero=0, busy=0, counter=0, and clear the internal registers.
REQ-027 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no ready and no hi/lo write.
REQ-028 The first start after reset deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro DIV_SIGNED_EN defined: signed two's-complement division per REQ-013/017/022/024.
REQ-030 Macro DIV_SIGNED_EN undefined: operands SHALL be treated as unsigned, sign capture and the FIX negation SHALL be removed, FIX SHALL remain as a pass-through cycle so latency is unchanged, and REQ-022 does not apply.

Verification
REQ-031 Normal divide: a=100, b=7 -> lo=14, hi=2; ready high exactly in the cycle after E34; busy high from E0 to E34.
REQ-032 Signed divide (DIV_SIGNED_EN): a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Overflow case: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Divide by zero: hi=5, lo=9 preloaded; a=123, b=0 -> div_zero pulse in the cycle after E0, ready never asserted, hi=5 and lo=9 unchanged.
REQ-034 Reset mid-operation: reset at E10 of a 100/7 run -> state IDLE, hi=lo=0, busy=0, no ready; a following 50/5 run -> lo=10, hi=0.
REQ-035 Start while busy: a second start with a=9, b=3 at E5 is ignored -> the single result is lo=14, hi=2, with one ready pulse.
REQ-036 Unsigned build (DIV_SIGNED_EN undefined): a=0xFFFFFFFF, b=2 -> lo=0x7FFFFFFF, hi=1, same latency as REQ-031.
